// File: rtl/dsp_route_scheduler.sv
// dsp_route_scheduler: double-buffered routing table for the DSP module bus.
// Software fills a shadow table of input/output selects; the whole table is
// copied to the active outputs in a single cycle on a commit event (commit-now,
// or arm + trigger rising edge, optionally followed by a programmable delay).
// Optional feature macro: ROUTE_SCHED_DELAY_EN adds the DELAY register and
// the DELAY state; without it an armed trigger commits on the next cycle.
//
// state    | meaning
// ST_IDLE  | no commit pending
// ST_ARMED | waiting for a trigger rising edge
// ST_DELAY | counting down from DELAY to the commit cycle
module dsp_route_scheduler #(
  parameter int MODULES     = 8,
  parameter int LOG_MODULES = 4,
  parameter int DEFAULT_IN  = 10,
  parameter int DELAY_BITS  = 32
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           trig_i,
  input  logic [15:0]                    sys_addr,
  input  logic [31:0]                    sys_wdata,
  input  logic                           sys_wen,
  input  logic                           sys_ren,
  output logic [31:0]                    sys_rdata,
  output logic                           sys_ack,
  output logic                           sys_err,
  output logic [MODULES*LOG_MODULES-1:0] in_sel_o,
  output logic [MODULES*2-1:0]           out_sel_o,
  output logic                           commit_o,
  output logic                           busy_o
);

  localparam int IDX_W = (MODULES > 1) ? $clog2(MODULES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   trig_q;
  logic                   commit_q;
  logic [31:0]            commits_q;
  logic [LOG_MODULES-1:0] sh_in_q  [MODULES];
  logic [LOG_MODULES-1:0] act_in_q [MODULES];
  logic [1:0]             sh_out_q [MODULES];
  logic [1:0]             act_out_q[MODULES];
  logic                   ack_q;
  logic                   err_q;
  logic [31:0]            rdata_q;
`ifdef ROUTE_SCHED_DELAY_EN
  logic [DELAY_BITS-1:0]  delay_q;
  logic [DELAY_BITS-1:0]  cnt_q;
`endif

  logic [7:0]       page;
  logic [IDX_W-1:0] idx;
  logic             idx_ok;
  logic             wr_ctrl, arm_req, now_req, abort_req;
  logic             wr_sh_in, wr_sh_out;
  logic             trig_rise;
  logic             do_commit;
  logic [31:0]      rd_c;
  logic             err_c;
  logic             unused_wdata;

  assign page      = sys_addr[15:8];
  assign idx       = sys_addr[IDX_W+1:2];
  assign idx_ok    = (sys_addr[1:0] == 2'b00) && (sys_addr[7:2] < 6'(MODULES));
  assign wr_ctrl   = sys_wen && (sys_addr == 16'h0000);
  assign arm_req   = wr_ctrl && sys_wdata[0];
  assign now_req   = wr_ctrl && sys_wdata[1];
  assign abort_req = wr_ctrl && sys_wdata[2];
  assign wr_sh_in  = sys_wen && (page == 8'h01) && idx_ok;
  assign wr_sh_out = sys_wen && (page == 8'h02) && idx_ok;
  assign trig_rise = trig_i && !trig_q;
  assign unused_wdata = ^sys_wdata;

  assign sys_ack   = ack_q;
  assign sys_err   = err_q;
  assign sys_rdata = rdata_q;
  assign commit_o  = commit_q;
  assign busy_o    = (state_q != ST_IDLE);

  // Commit decision for this cycle; abort overrides every commit source.
  always_comb begin
    do_commit = 1'b0;
    if (abort_req) begin
      do_commit = 1'b0;
    end else if (now_req) begin
      do_commit = 1'b1;
    end else if (state_q == ST_ARMED && trig_rise) begin
`ifdef ROUTE_SCHED_DELAY_EN
      do_commit = (delay_q == '0);
`else
      do_commit = 1'b1;
`endif
    end
`ifdef ROUTE_SCHED_DELAY_EN
    else if (state_q == ST_DELAY && cnt_q == DELAY_BITS'(1)) begin
      do_commit = 1'b1;
    end
`endif
  end

  // Sequencing FSM, commit pulse, commit counter and trigger edge register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      commit_q  <= 1'b0;
      commits_q <= '0;
`ifdef ROUTE_SCHED_DELAY_EN
      cnt_q     <= '0;
`endif
    end else begin
      trig_q   <= trig_i;
      commit_q <= do_commit;
      if (do_commit) commits_q <= commits_q + 32'd1;
      if (abort_req || now_req) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (arm_req) state_q <= ST_ARMED;
          ST_ARMED: begin
            if (trig_rise) begin
`ifdef ROUTE_SCHED_DELAY_EN
              if (delay_q == '0) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_DELAY;
                cnt_q   <= delay_q;
              end
`else
              state_q <= ST_IDLE;
`endif
            end
          end
`ifdef ROUTE_SCHED_DELAY_EN
          ST_DELAY: begin
            if (cnt_q == DELAY_BITS'(1)) state_q <= ST_IDLE;
            else                         cnt_q   <= cnt_q - DELAY_BITS'(1);
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ROUTE_SCHED_DELAY_EN
  // Trigger-to-commit delay register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) delay_q <= '0;
    else if (sys_wen && sys_addr == 16'h0008) delay_q <= sys_wdata[DELAY_BITS-1:0];
  end
`endif

  // Shadow writes and shadow-to-active copy; the copy sees pre-write shadow values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < MODULES; k++) begin
        sh_in_q[k]   <= LOG_MODULES'(DEFAULT_IN);
        act_in_q[k]  <= LOG_MODULES'(DEFAULT_IN);
        sh_out_q[k]  <= 2'b00;
        act_out_q[k] <= 2'b00;
      end
    end else begin
      if (wr_sh_in)  sh_in_q[idx]  <= sys_wdata[LOG_MODULES-1:0];
      if (wr_sh_out) sh_out_q[idx] <= sys_wdata[1:0];
      if (do_commit) begin
        for (int k = 0; k < MODULES; k++) begin
          act_in_q[k]  <= sh_in_q[k];
          act_out_q[k] <= sh_out_q[k];
        end
      end
    end
  end

  // Flatten the active table onto the routing outputs.
  always_comb begin
    in_sel_o  = '0;
    out_sel_o = '0;
    for (int k = 0; k < MODULES; k++) begin
      in_sel_o[k*LOG_MODULES +: LOG_MODULES] = act_in_q[k];
      out_sel_o[2*k +: 2]                    = act_out_q[k];
    end
  end

  // Read data mux and unmapped-offset detection.
  always_comb begin
    rd_c  = '0;
    err_c = 1'b0;
    case (sys_addr)
      16'h0000: rd_c = '0;
      16'h0004: rd_c = {30'd0, state_q};
`ifdef ROUTE_SCHED_DELAY_EN
      16'h0008: rd_c = 32'(delay_q);
`else
      16'h0008: rd_c = '0;
`endif
      16'h000C: rd_c = commits_q;
      default: begin
        if (!idx_ok) begin
          err_c = 1'b1;
        end else begin
          case (page)
            8'h01:   rd_c = 32'(sh_in_q[idx]);
            8'h02:   rd_c = 32'(sh_out_q[idx]);
            8'h03:   rd_c = 32'(act_in_q[idx]);
            8'h04:   rd_c = 32'(act_out_q[idx]);
            default: err_c = 1'b1;
          endcase
        end
      end
    endcase
  end

  // Registered bus response, one cycle after the strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= sys_wen || sys_ren;
      err_q   <= (sys_wen || sys_ren) && err_c;
      rdata_q <= (sys_ren && !err_c) ? rd_c : 32'd0;
    end
  end

endmodule

// File: tb/tb_dsp_route_scheduler.sv
// Self-checking bench for dsp_route_scheduler with a table-level reference model.
module tb_dsp_route_scheduler;
  localparam int M = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        ack, err;
  logic [31:0] in_sel;
  logic [15:0] out_sel;
  logic        commit, busy;

  dsp_route_scheduler dut (
    .clk_i(clk), .rstn_i(rstn), .trig_i(trig),
    .sys_addr(addr), .sys_wdata(wdata), .sys_wen(wen), .sys_ren(ren),
    .sys_rdata(rdata), .sys_ack(ack), .sys_err(err),
    .in_sel_o(in_sel), .out_sel_o(out_sel), .commit_o(commit), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0]  m_sh_in  [M];
  logic [3:0]  m_act_in [M];
  logic [1:0]  m_sh_out [M];
  logic [1:0]  m_act_out[M];
  logic [31:0] m_commits;
  int          m_delay;

  logic        s_ack, s_err, s_commit;
  logic [31:0] s_rdata;

  function automatic void model_reset();
    for (int k = 0; k < M; k++) begin
      m_sh_in[k] = 4'd10; m_act_in[k] = 4'd10; m_sh_out[k] = 2'd0; m_act_out[k] = 2'd0;
    end
    m_commits = 0;
    m_delay = 0;
  endfunction

  function automatic void model_commit();
    for (int k = 0; k < M; k++) begin
      m_act_in[k] = m_sh_in[k]; m_act_out[k] = m_sh_out[k];
    end
    m_commits = m_commits + 1;
  endfunction

  function automatic logic [31:0] exp_in();
    logic [31:0] v = '0;
    for (int k = 0; k < M; k++) v[4*k +: 4] = m_act_in[k];
    return v;
  endfunction

  function automatic logic [15:0] exp_out();
    logic [15:0] v = '0;
    for (int k = 0; k < M; k++) v[2*k +: 2] = m_act_out[k];
    return v;
  endfunction

  // DELAY only exists when the feature is compiled in; otherwise writes are ignored.
  function automatic int model_delay(input int d);
`ifdef ROUTE_SCHED_DELAY_EN
    return d;
`else
    return 0;
`endif
  endfunction

  task automatic bus(input bit wr, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wen = wr; ren = !wr;
    @(posedge clk); #1;
    s_ack = ack; s_err = err; s_rdata = rdata; s_commit = commit;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    if (in_sel !== exp_in()) begin bad++; $display("FAIL reset_in_sel got=%h exp=%h", in_sel, exp_in()); end
    total++;
    if (out_sel !== exp_out()) begin bad++; $display("FAIL reset_out_sel got=%h exp=%h", out_sel, exp_out()); end
    total++;
    if ({commit, busy, ack, err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {commit, busy, ack, err}); end
    total++;
    if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++;
    for (int k = 0; k < M; k++) begin
      bus(0, 16'h0300 + 16'(4*k), 0);
      total++;
      if (s_rdata !== 32'(m_act_in[k])) begin bad++; $display("FAIL reset_rd_act_in[%0d] got=%h exp=%h", k, s_rdata, m_act_in[k]); end
      bus(0, 16'h0400 + 16'(4*k), 0);
      total++;
      if (s_rdata !== 32'(m_act_out[k])) begin bad++; $display("FAIL reset_rd_act_out[%0d] got=%h exp=%h", k, s_rdata, m_act_out[k]); end
    end
    bus(0, 16'h0004, 0);
    total++;
    if (s_rdata !== 32'd0 || s_ack !== 1'b1) begin bad++; $display("FAIL reset_status got=%h ack=%b exp=0 ack=1", s_rdata, s_ack); end
    bus(0, 16'h000C, 0);
    total++;
    if (s_rdata !== m_commits) begin bad++; $display("FAIL reset_commits got=%0d exp=%0d", s_rdata, m_commits); end
  endtask

  task automatic test_commit_now();
    bus(1, 16'h010C, 32'd2); m_sh_in[3] = 4'd2;
    bus(1, 16'h020C, 32'd1); m_sh_out[3] = 2'd1;
    total++;
    if (in_sel !== exp_in() || out_sel !== exp_out()) begin bad++; $display("FAIL shadow_leak got=%h/%h exp=%h/%h", in_sel, out_sel, exp_in(), exp_out()); end
    bus(1, 16'h0000, 32'd2);
    model_commit();
    total++;
    if (s_commit !== 1'b1) begin bad++; $display("FAIL now_commit_pulse got=%b exp=1", s_commit); end
    total++;
    if (in_sel[15:12] !== 4'd2 || out_sel[7:6] !== 2'd1) begin bad++; $display("FAIL now_entry3 got=%h/%h exp=2/1", in_sel[15:12], out_sel[7:6]); end
    total++;
    if (in_sel !== exp_in() || out_sel !== exp_out()) begin bad++; $display("FAIL now_tables got=%h/%h exp=%h/%h", in_sel, out_sel, exp_in(), exp_out()); end
    @(posedge clk); #1;
    total++;
    if (commit !== 1'b0) begin bad++; $display("FAIL now_pulse_width got=%b exp=0", commit); end
    bus(0, 16'h000C, 0);
    total++;
    if (s_rdata !== m_commits) begin bad++; $display("FAIL now_commits got=%0d exp=%0d", s_rdata, m_commits); end
  endtask

  task automatic random_shadow_writes(input int n);
    for (int j = 0; j < n; j++) begin
      int k = $urandom_range(0, M-1);
      logic [31:0] d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        bus(1, 16'h0100 + 16'(4*k), d); m_sh_in[k] = d[3:0];
      end else begin
        bus(1, 16'h0200 + 16'(4*k), d); m_sh_out[k] = d[1:0];
      end
    end
  endtask

  task automatic test_random_commits();
    for (int it = 0; it < 15; it++) begin
      int k = $urandom_range(0, M-1);
      random_shadow_writes($urandom_range(1, 6));
      bus(0, 16'h0100 + 16'(4*k), 0);
      total++;
      if (s_rdata !== 32'(m_sh_in[k])) begin bad++; $display("FAIL rnd_rd_sh_in[%0d] got=%h exp=%h", k, s_rdata, m_sh_in[k]); end
      bus(0, 16'h0200 + 16'(4*k), 0);
      total++;
      if (s_rdata !== 32'(m_sh_out[k])) begin bad++; $display("FAIL rnd_rd_sh_out[%0d] got=%h exp=%h", k, s_rdata, m_sh_out[k]); end
      bus(1, 16'h0000, 32'd2);
      model_commit();
      total++;
      if (s_commit !== 1'b1 || in_sel !== exp_in() || out_sel !== exp_out())
        begin bad++; $display("FAIL rnd_commit it=%0d got=%b %h/%h exp=1 %h/%h", it, s_commit, in_sel, out_sel, exp_in(), exp_out()); end
    end
    bus(0, 16'h000C, 0);
    total++;
    if (s_rdata !== m_commits) begin bad++; $display("FAIL rnd_commits got=%0d exp=%0d", s_rdata, m_commits); end
  endtask

  task automatic test_trigger();
    int dv[4];
    dv[0] = 0; dv[1] = 5; dv[2] = 1; dv[3] = $urandom_range(2, 9);
    for (int t = 0; t < 4; t++) begin
      bus(1, 16'h0008, 32'(dv[t])); m_delay = model_delay(dv[t]);
      bus(0, 16'h0008, 0);
      total++;
      if (s_rdata !== 32'(m_delay)) begin bad++; $display("FAIL trg_delay_rd got=%0d exp=%0d", s_rdata, m_delay); end
      random_shadow_writes(3);
      bus(1, 16'h0000, 32'd1);
      total++;
      if (busy !== 1'b1 || s_commit !== 1'b0) begin bad++; $display("FAIL trg_armed busy=%b commit=%b exp=1/0", busy, s_commit); end
      bus(0, 16'h0004, 0);
      total++;
      if (s_rdata !== 32'd1) begin bad++; $display("FAIL trg_status_armed got=%0d exp=1", s_rdata); end
      @(negedge clk); trig = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i <= m_delay + 2; i++) begin
        if (i == m_delay) model_commit();
        total++;
        if (commit !== (i == m_delay) || busy !== (i < m_delay) || in_sel !== exp_in() || out_sel !== exp_out())
          begin bad++; $display("FAIL trg_seq d=%0d i=%0d commit=%b busy=%b in=%h exp_in=%h", m_delay, i, commit, busy, in_sel, exp_in()); end
        @(negedge clk); trig = 1'b0;
        @(posedge clk); #1;
      end
      bus(0, 16'h0004, 0);
      total++;
      if (s_rdata !== 32'd0) begin bad++; $display("FAIL trg_status_idle got=%0d exp=0", s_rdata); end
    end
    random_shadow_writes(2);
    @(negedge clk); trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (commit !== 1'b0 || in_sel !== exp_in()) begin bad++; $display("FAIL trg_idle_ignored i=%0d commit=%b in=%h exp=0 %h", i, commit, in_sel, exp_in()); end
    end
    @(negedge clk); trig = 1'b0;
  endtask

  task automatic test_same_cycle();
    bus(1, 16'h0008, 32'd0); m_delay = 0;
    bus(1, 16'h0100, 32'd5); m_sh_in[0] = 4'd5;
    bus(1, 16'h0000, 32'd2); model_commit();
    bus(1, 16'h0000, 32'd1);
    @(negedge clk);
    addr = 16'h0100; wdata = 32'd7; wen = 1'b1; trig = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    model_commit(); m_sh_in[0] = 4'd7;
    total++;
    if (commit !== 1'b1 || in_sel[3:0] !== 4'd5 || in_sel !== exp_in())
      begin bad++; $display("FAIL same_cycle commit=%b in0=%h exp=1 %h", commit, in_sel[3:0], m_act_in[0]); end
    @(negedge clk); trig = 1'b0;
    bus(0, 16'h0100, 0);
    total++;
    if (s_rdata !== 32'd7) begin bad++; $display("FAIL same_cycle_shadow got=%h exp=7", s_rdata); end
    bus(1, 16'h0000, 32'd2); model_commit();
    total++;
    if (in_sel[3:0] !== 4'd7 || in_sel !== exp_in()) begin bad++; $display("FAIL second_commit got=%h exp=7", in_sel[3:0]); end
    bus(1, 16'h0104, 32'd3); m_sh_in[1] = 4'd3;
    bus(1, 16'h0000, 32'd6);
    total++;
    if (s_commit !== 1'b0 || in_sel !== exp_in()) begin bad++; $display("FAIL abort_beats_now commit=%b in=%h exp=0 %h", s_commit, in_sel, exp_in()); end
    bus(1, 16'h0000, 32'd1);
    bus(1, 16'h0000, 32'd4);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_armed busy=%b exp=0", busy); end
    @(negedge clk); trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (commit !== 1'b0 || in_sel !== exp_in()) begin bad++; $display("FAIL abort_no_commit i=%0d commit=%b", i, commit); end
    end
    @(negedge clk); trig = 1'b0;
    bus(0, 16'h000C, 0);
    total++;
    if (s_rdata !== m_commits) begin bad++; $display("FAIL abort_commits got=%0d exp=%0d", s_rdata, m_commits); end
  endtask

  task automatic test_abort_delay();
    bus(1, 16'h0008, 32'd100); m_delay = model_delay(100);
    if (m_delay > 0) begin
      bus(1, 16'h0000, 32'd1);
      @(negedge clk); trig = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #1;
        total++;
        if (commit !== 1'b0) begin bad++; $display("FAIL abort_delay_early i=%0d commit=%b exp=0", i, commit); end
        @(negedge clk); trig = 1'b0;
      end
      bus(1, 16'h0000, 32'd4);
      bus(0, 16'h0004, 0);
      total++;
      if (s_rdata !== 32'd0) begin bad++; $display("FAIL abort_delay_status got=%0d exp=0", s_rdata); end
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        total++;
        if (commit !== 1'b0) begin bad++; $display("FAIL abort_delay_late i=%0d commit=%b exp=0", i, commit); end
      end
    end
  endtask

  task automatic test_bus_errors();
    bus(0, 16'h0100 + 16'(4*M), 0);
    total++;
    if (s_ack !== 1'b1 || s_err !== 1'b1) begin bad++; $display("FAIL err_idx ack=%b err=%b exp=1/1", s_ack, s_err); end
    bus(0, 16'h0500, 0);
    total++;
    if (s_ack !== 1'b1 || s_err !== 1'b1 || s_rdata !== 32'd0) begin bad++; $display("FAIL err_500 ack=%b err=%b rd=%h exp=1/1/0", s_ack, s_err, s_rdata); end
    bus(0, 16'h0102, 0);
    total++;
    if (s_err !== 1'b1) begin bad++; $display("FAIL err_misaligned err=%b exp=1", s_err); end
    bus(1, 16'h0300, 32'd3);
    total++;
    if (s_ack !== 1'b1 || s_err !== 1'b0 || in_sel !== exp_in()) begin bad++; $display("FAIL wr_ro_active ack=%b err=%b in=%h exp=1/0 %h", s_ack, s_err, in_sel, exp_in()); end
    bus(1, 16'h000C, 32'd99);
    bus(0, 16'h000C, 0);
    total++;
    if (s_rdata !== m_commits || s_err !== 1'b0) begin bad++; $display("FAIL wr_ro_commits got=%0d exp=%0d", s_rdata, m_commits); end
  endtask

  task automatic test_async_reset();
    bus(1, 16'h0108, 32'd4); m_sh_in[2] = 4'd4;
    bus(1, 16'h0000, 32'd2); model_commit();
    bus(1, 16'h0008, 32'd100); m_delay = model_delay(100);
    bus(1, 16'h0000, 32'd1);
    if (m_delay > 0) begin
      @(negedge clk); trig = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk); trig = 1'b0;
    end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    model_reset();
    total++;
    if (in_sel !== exp_in() || out_sel !== exp_out() || busy !== 1'b0 || commit !== 1'b0)
      begin bad++; $display("FAIL async_reset in=%h out=%h busy=%b exp=%h %h 0", in_sel, out_sel, busy, exp_in(), exp_out()); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (commit !== 1'b0 || in_sel !== exp_in()) begin bad++; $display("FAIL post_reset_commit i=%0d commit=%b", i, commit); end
    end
    @(negedge clk); trig = 1'b0;
    bus(0, 16'h0108, 0);
    total++;
    if (s_rdata !== 32'(m_sh_in[2])) begin bad++; $display("FAIL post_reset_shadow got=%h exp=%h", s_rdata, m_sh_in[2]); end
    bus(0, 16'h000C, 0);
    total++;
    if (s_rdata !== m_commits) begin bad++; $display("FAIL post_reset_commits got=%0d exp=%0d", s_rdata, m_commits); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_commit_now();
    test_random_commits();
    test_trigger();
    test_same_cycle();
    test_abort_delay();
    test_bus_errors();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
